// File: rtl/timer_multi_pkg.sv
// Shared types and helpers for the multi-channel timer.
package timer_multi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } ch_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Widest register the helper supports; callers zero-extend into it.
  localparam int unsigned RegMax = 64;

  function automatic logic [RegMax-1:0] nz_or_one(input logic [RegMax-1:0] x);
    return (x == '0) ? {{(RegMax-1){1'b0}}, 1'b1} : x;
  endfunction

endpackage

// File: rtl/timer_multi_if.sv
// Control/status bundle of timer_multi: master drives the i_* side, slave is the timer.
interface timer_multi_if #(
  parameter int unsigned N_REG = 32,
  parameter int unsigned N_CH  = 4
);
  logic [N_REG-1:0]      i_prescale;
  logic [N_CH*N_REG-1:0] i_value;
  logic [N_CH-1:0]       i_mode;
  logic [N_CH-1:0]       i_enable;
  logic [N_CH-1:0]       i_clear;
  logic [N_CH-1:0]       i_irq_mask;
  logic [N_CH-1:0]       i_irq_ack;
  logic [N_CH*N_REG-1:0] o_count;
  logic [N_CH-1:0]       o_pending;
  logic [N_CH-1:0]       o_running;
  logic                  o_interrupt;

  modport master (
    output i_prescale, i_value, i_mode, i_enable, i_clear, i_irq_mask, i_irq_ack,
    input  o_count, o_pending, o_running, o_interrupt
  );

  modport slave (
    input  i_prescale, i_value, i_mode, i_enable, i_clear, i_irq_mask, i_irq_ack,
    output o_count, o_pending, o_running, o_interrupt
  );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, compare counter and sticky pending flag.
module timer_channel
  import timer_multi_pkg::*;
#(
  parameter int unsigned N_REG = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic [N_REG-1:0] i_value,
  input  logic             i_mode,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_ack,
  output logic [N_REG-1:0] o_count,
  output logic             o_pending,
  output logic             o_running
);

  ch_state_e         state_q, state_d;
  logic [N_REG-1:0]  count_q, count_d;
  logic              pending_q, pending_d;
  logic              expire;
  logic [RegMax-1:0] v_last;

  assign v_last = nz_or_one(RegMax'(i_value)) - RegMax'(1);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = pending_q;
    expire    = 1'b0;

    if (i_clear) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_enable) state_d = StRun;
        end
        StRun: begin
          if (i_enable && i_tick) begin
            // >= so that lowering V below the count expires on the next tick
            if (RegMax'(count_q) >= v_last) begin
              expire = 1'b1;
              if (i_mode == MODE_ONESHOT) state_d = StDone;
              else                        count_d = '0;
            end else begin
              count_d = count_q + N_REG'(1);
            end
          end
        end
        StDone: ;
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end

    if (i_clear)     pending_d = 1'b0;
    else if (expire) pending_d = 1'b1;
    else if (i_ack)  pending_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign o_count   = count_q;
  assign o_pending = pending_q;
  assign o_running = (state_q == StRun) && i_enable;

endmodule

// File: rtl/timer_multi.sv
// N_CH-channel timer sharing one prescaler; unmasked pending flags ORed into one interrupt.
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int unsigned N_REG = 32,
  parameter int unsigned N_CH  = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  timer_multi_if.slave bus_io
);

  logic [N_REG-1:0]      pre_cnt_q, pre_cnt_d;
  logic [RegMax-1:0]     p_last;
  logic                  en_any;
  logic                  tick;
  logic [N_CH*N_REG-1:0] count;
  logic [N_CH-1:0]       pending;
  logic [N_CH-1:0]       running;

  assign en_any = |bus_io.i_enable;
  assign p_last = nz_or_one(RegMax'(bus_io.i_prescale)) - RegMax'(1);
  assign tick   = en_any && (RegMax'(pre_cnt_q) == p_last);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (&bus_io.i_clear) begin
      pre_cnt_d = '0;
    end else if (en_any) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + N_REG'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) pre_cnt_q <= '0;
    else       pre_cnt_q <= pre_cnt_d;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    timer_channel #(
      .N_REG(N_REG)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_tick   (tick),
      .i_value  (bus_io.i_value[k*N_REG +: N_REG]),
      .i_mode   (bus_io.i_mode[k]),
      .i_enable (bus_io.i_enable[k]),
      .i_clear  (bus_io.i_clear[k]),
      .i_ack    (bus_io.i_irq_ack[k]),
      .o_count  (count[k*N_REG +: N_REG]),
      .o_pending(pending[k]),
      .o_running(running[k])
    );
  end

  assign bus_io.o_count     = count;
  assign bus_io.o_pending   = pending;
  assign bus_io.o_running   = running;
  assign bus_io.o_interrupt = |(pending & ~bus_io.i_irq_mask);

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: directed scenarios plus random stimulus against a cycle model.
module tb_timer_multi;

  localparam int unsigned NReg = 32;
  localparam int unsigned NCh  = 4;
  localparam int unsigned W    = NCh * NReg;
  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MDone = 2;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  timer_multi_if #(.N_REG(NReg), .N_CH(NCh)) bus ();

  timer_multi #(
    .N_REG(NReg),
    .N_CH (NCh)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus_io(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int unsigned m_pre;
  int          m_st [NCh];
  int unsigned m_cnt[NCh];
  bit          m_pend[NCh];
  bit          started = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int unsigned p_eff, v_eff, v;
    bit tick, expire;
    if (i_rst) begin
      m_pre = 0;
      for (int k = 0; k < NCh; k++) begin
        m_st[k] = MIdle; m_cnt[k] = 0; m_pend[k] = 1'b0;
      end
      started = 1'b1;
      return;
    end
    p_eff = (bus.i_prescale == 0) ? 1 : bus.i_prescale;
    tick  = (|bus.i_enable) && (m_pre == p_eff - 1);
    if (&bus.i_clear)       m_pre = 0;
    else if (|bus.i_enable) m_pre = tick ? 0 : m_pre + 1;
    for (int k = 0; k < NCh; k++) begin
      v      = bus.i_value[k*NReg +: NReg];
      v_eff  = (v == 0) ? 1 : v;
      expire = 1'b0;
      if (bus.i_clear[k]) begin
        m_st[k] = MIdle; m_cnt[k] = 0; m_pend[k] = 1'b0;
      end else begin
        if (m_st[k] == MIdle) begin
          if (bus.i_enable[k]) m_st[k] = MRun;
        end else if (m_st[k] == MRun && bus.i_enable[k] && tick) begin
          if (m_cnt[k] >= v_eff - 1) begin
            expire = 1'b1;
            if (bus.i_mode[k]) m_st[k] = MDone;
            else               m_cnt[k] = 0;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
        if (expire)                m_pend[k] = 1'b1;
        else if (bus.i_irq_ack[k]) m_pend[k] = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    model_step();
  end

  // Compare every cycle on the falling edge, once the model has seen reset
  initial forever begin
    logic [W-1:0]   ec;
    logic [NCh-1:0] ep, er;
    @(negedge i_clk);
    if (started) begin
      for (int k = 0; k < NCh; k++) begin
        ec[k*NReg +: NReg] = m_cnt[k];
        ep[k] = m_pend[k];
        er[k] = (m_st[k] == MRun) && bus.i_enable[k];
      end
      chk("count", bus.o_count, ec);
      chk("pending", W'(bus.o_pending), W'(ep));
      chk("running", W'(bus.o_running), W'(er));
      chk("interrupt", W'(bus.o_interrupt), W'(|(ep & ~bus.i_irq_mask)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic set_v(input int k, input logic [NReg-1:0] v);
    bus.i_value[k*NReg +: NReg] = v;
  endtask

  function automatic logic [NReg-1:0] cnt_of(input int k);
    return bus.o_count[k*NReg +: NReg];
  endfunction

  task automatic clear_all();
    bus.i_enable  = '0;
    bus.i_irq_ack = '0;
    bus.i_clear   = '1;
    cyc(1);
    bus.i_clear   = '0;
  endtask

  initial begin
    int rises[$];
    int irq_hi, max_cnt, n_set;
    bit prev;

    i_rst          = 1'b1;
    bus.i_prescale = '0;
    bus.i_value    = '0;
    bus.i_mode     = '0;
    bus.i_enable   = '0;
    bus.i_clear    = '0;
    bus.i_irq_mask = '0;
    bus.i_irq_ack  = '0;
    cyc(3);
    chk("rst_count", bus.o_count, W'(0));
    chk("rst_pending", W'(bus.o_pending), W'(0));
    chk("rst_running", W'(bus.o_running), W'(0));
    chk("rst_irq", W'(bus.o_interrupt), W'(0));
    i_rst = 1'b0;

    // Periodic P=4 V=3 on ch0, acking each set
    bus.i_prescale = 4;
    set_v(0, 3);
    bus.i_enable = 4'b0001;
    irq_hi = 0; max_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (bus.o_pending[0]) rises.push_back(i);
      if (bus.o_interrupt) irq_hi++;
      if (int'(cnt_of(0)) > max_cnt) max_cnt = int'(cnt_of(0));
      bus.i_irq_ack[0] = bus.o_pending[0];
    end
    chk("per_nsets", W'(rises.size()), W'(5));
    if (rises.size() >= 3) begin
      chk("per_first", W'(rises[0]), W'(11));
      chk("per_period", W'(rises[1] - rises[0]), W'(12));
      chk("per_period2", W'(rises[2] - rises[1]), W'(12));
    end
    chk("per_irq_pulses", W'(irq_hi), W'(5));
    chk("per_max_cnt", W'(max_cnt), W'(2));
    clear_all();

    // One-shot P=1 V=5 on ch1
    bus.i_prescale = 1;
    set_v(1, 5);
    bus.i_mode   = 4'b0010;
    bus.i_enable = 4'b0010;
    n_set = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (bus.o_pending[1] && !prev) n_set++;
      prev = bus.o_pending[1];
    end
    chk("os_nsets", W'(n_set), W'(1));
    chk("os_count", W'(cnt_of(1)), W'(4));
    chk("os_running", W'(bus.o_running[1]), W'(0));
    bus.i_clear = 4'b0010;
    cyc(1);
    chk("os_clr_count", W'(cnt_of(1)), W'(0));
    chk("os_clr_pend", W'(bus.o_pending[1]), W'(0));
    bus.i_mode = '0;
    clear_all();

    // Zero operands with ack held: expiry every cycle beats the ack
    bus.i_prescale = 0;
    set_v(0, 0);
    bus.i_enable  = 4'b0001;
    bus.i_irq_ack = 4'b0001;
    cyc(6);
    chk("zero_pend", W'(bus.o_pending[0]), W'(1));
    chk("zero_count", W'(cnt_of(0)), W'(0));
    clear_all();

    // Pause at 7, then lower V below the count
    bus.i_prescale = 1;
    set_v(2, 20);
    bus.i_enable = 4'b0100;
    cyc(8);
    chk("pause_at7", W'(cnt_of(2)), W'(7));
    bus.i_enable = '0;
    cyc(10);
    chk("pause_hold", W'(cnt_of(2)), W'(7));
    chk("pause_run", W'(bus.o_running[2]), W'(0));
    set_v(2, 5);
    bus.i_enable = 4'b0100;
    cyc(1);
    chk("lowv_count", W'(cnt_of(2)), W'(0));
    chk("lowv_pend", W'(bus.o_pending[2]), W'(1));
    bus.i_enable = '0;

    // Masking hides but keeps pending; unmask is immediate
    bus.i_irq_mask = 4'b0100;
    #1;
    chk("mask_irq", W'(bus.o_interrupt), W'(0));
    chk("mask_pend", W'(bus.o_pending[2]), W'(1));
    bus.i_irq_mask = '0;
    #1;
    chk("unmask_irq", W'(bus.o_interrupt), W'(1));
    clear_all();

    // Reset while every channel runs with pending set
    bus.i_prescale = 1;
    for (int k = 0; k < NCh; k++) set_v(k, 2);
    bus.i_enable = '1;
    cyc(4);
    chk("pre_rst_pend", W'(bus.o_pending), W'(4'hF));
    i_rst = 1'b1;
    cyc(1);
    chk("mid_rst_count", bus.o_count, W'(0));
    chk("mid_rst_pend", W'(bus.o_pending), W'(0));
    chk("mid_rst_irq", W'(bus.o_interrupt), W'(0));
    chk("mid_rst_run", W'(bus.o_running), W'(0));
    i_rst = 1'b0;
    clear_all();

    // Random traffic; P only changes together with an all-channel clear
    for (int i = 0; i < 3000; i++) begin
      bus.i_clear = '0;
      if ($urandom_range(39) == 0) begin
        bus.i_clear    = '1;
        bus.i_prescale = $urandom_range(3);
      end else begin
        for (int k = 0; k < NCh; k++) bus.i_clear[k] = ($urandom_range(63) == 0);
      end
      if ($urandom_range(15) == 0) set_v(int'($urandom_range(NCh - 1)), $urandom_range(7));
      if ($urandom_range(31) == 0) bus.i_mode = NCh'($urandom);
      for (int k = 0; k < NCh; k++) begin
        bus.i_enable[k]  = ($urandom_range(7) != 0);
        bus.i_irq_ack[k] = ($urandom_range(3) == 0);
      end
      if ($urandom_range(7) == 0) bus.i_irq_mask = NCh'($urandom);
      i_rst = ($urandom_range(499) == 0);
      cyc(1);
    end
    i_rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Multi-channel successor to the single-channel timer. Provides N_CH independent counters driven by one shared prescaler.
- Each channel has its own compare value and runs in either periodic or one-shot mode.
- Each channel has a sticky pending flag with acknowledge and mask. All unmasked pending flags are ORed into one interrupt line for the SoC interrupt controller.

Parameters:
- N_REG, 32, width of the prescale value, compare values and counters.
- N_CH, 4, number of timer channels (1..32).

Ports:
- i_clk  input  1  system clock; sole clock domain.
- i_rst  input  1  reset; synchronous and active-high.
- i_prescale  input  N_REG  shared prescale divisor P; 0 is treated as 1.
- i_value  input  N_CH*N_REG  per-channel compare value V, channel k in bits [k*N_REG +: N_REG]; 0 is treated as 1.
- i_mode  input  N_CH  per channel: 0 = periodic, 1 = one-shot.
- i_enable  input  N_CH  per-channel run enable (level).
- i_clear  input  N_CH  per-channel synchronous clear (level).
- i_irq_mask  input  N_CH  1 = pending flag does not drive o_interrupt.
- i_irq_ack  input  N_CH  single-cycle acknowledge; clears pending.
- o_count  output  N_CH*N_REG  per-channel counter value, registered.
- o_pending  output  N_CH  per-channel sticky expiry flag, registered.
- o_running  output  N_CH  channel is in RUN state and enabled.
- o_interrupt  output  1  equals |(o_pending & ~i_irq_mask).

Behaviour:
- Reset (i_rst=1 at a clock edge): prescaler, all counters and all pending flags go to 0; all channels go to IDLE. o_interrupt=0 and o_running=0 in the following cycle. Reset has priority over every other input.
- Prescaler:
  - pre_cnt advances only while |i_enable=1; otherwise it holds.
  - It wraps at P_eff-1, where P_eff = max(P,1).
  - tick = (|i_enable) && (pre_cnt == P_eff-1). With P_eff=1, tick is high on every enabled cycle.
  - pre_cnt is cleared only by reset, or when every i_clear bit is 1.
- Channel FSM, states IDLE, RUN, DONE:
  - IDLE: count=0. i_enable=1 moves the channel to RUN on the next edge; no counting happens in that cycle.
  - RUN with i_enable=1 and tick=1:
    - If count >= V_eff-1 (V_eff = max(V,1)), the channel expires.
    - Periodic expiry: count <= 0; stay in RUN.
    - One-shot expiry: count holds; go to DONE.
    - Otherwise count <= count+1.
  - RUN with i_enable=0: pause; count holds; state stays RUN; o_running=0.
  - DONE: count frozen; i_enable ignored; o_running=0. Leaves only via i_clear or reset.
  - i_clear (any state): next edge gives count=0, state IDLE, pending=0. Clear beats enable, tick and expiry in the same cycle.
- Compare uses >=. If V is lowered below the current count mid-run, the channel expires on the next tick; there is no 2^N_REG wrap.
- count + 1 is N_REG-bit arithmetic. Overflow is unreachable because of the >= compare.
- Pending flag:
  - Set on the edge where expiry occurs; visible one cycle after the expiring tick.
  - i_irq_ack clears it.
  - Expiry and ack in the same cycle: set wins, pending=1.
  - Ack with pending=0 has no effect.
- o_interrupt is combinational from registered o_pending and i_irq_mask. Masking does not clear pending; unmasking re-asserts o_interrupt immediately.
- Expiry period = P_eff * V_eff cycles between pending sets in periodic mode, with all enables held high.
- Channels are fully independent, apart from sharing the prescaler phase.

Decomposition:
- Package timer_multi_pkg holds:
  - channel state enum (IDLE, RUN, DONE);
  - mode constants MODE_PERIODIC=1'b0 and MODE_ONESHOT=1'b1;
  - a helper function nz_or_one(x) returning max(x,1).
- Sub-module timer_channel holds one channel's FSM, counter and pending flag. Its inputs are tick, V, mode, enable, clear and ack; its outputs are count, pending and running.
- timer_multi contains the prescaler, a generate loop of N_CH timer_channel instances, and the interrupt OR.

Test Plan:
- Periodic: P=4, V=3, ch0 periodic, enable held -> o_pending[0] sets every 12 cycles after the start-up latency; o_count[0] cycles 0,1,2. Ack each cycle after the set -> o_interrupt pulses for 1 cycle per period.
- One-shot: P=1, V=5, ch1 one-shot -> pending set once, state DONE, o_count[1]=4 frozen. No further sets after 100 cycles; i_clear -> count 0, IDLE, pending 0.
- Zero operands: P=0, V=0 -> behaves as P=1, V=1, so pending sets every cycle. Ack issued in a cycle where expiry also occurs -> pending stays 1.
- Pause and V change: stop enable mid-count at count=7 (V=20) -> count holds 7 for 10 cycles. Lower V to 5 and re-enable -> expiry on the next tick.
- Mask and multi-channel: N_CH=4, ch2 masked and expiring -> o_pending[2]=1, o_interrupt=0. Unmask -> o_interrupt=1 in the same cycle.
- Reset mid-run: assert i_rst while all channels are in RUN with pending set -> next cycle all counts, pending and o_interrupt are 0 and all states are IDLE.
